serial_adder_ctrl: RTL and testbench

- Bit-serial multi-bit adder built from one shared `Full_Adder` instance (ports `A`, `B`, `Cin`, `Sum`, `Carry`).
- Captures two WIDTH-bit operands plus carry-in on a start handshake.
- Feeds the full adder one bit pair per cycle, LSB first, through shift registers and a carry flip-flop.
- Reports the WIDTH-bit sum and carry-out with a done pulse.
- Intended as the area-cheap adder option for multi-bit datapaths in the combinational-logic library.

---
 rtl/serial_adder_ctrl_if.sv | 24 ++
 rtl/serial_adder_ctrl.sv | 110 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Handshake and result bundle for the bit-serial adder.
// Master drives the request side, slave returns status and result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder reused WIDTH times, LSB first.
// Result and carry-out are latched on the last RUN edge.
module Full_Adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Carry
);
    assign Sum   = A ^ B ^ Cin;
    assign Carry = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nx;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             fa_s;
    logic             fa_c;
    logic             last;
    logic             accept;

    Full_Adder u_fa (
        .A     (a_sh[0]),
        .B     (b_sh[0]),
        .Cin   (carry),
        .Sum   (fa_s),
        .Carry (fa_c)
    );

    assign last   = (cnt == LAST);
    assign accept = (state == IDLE) && bus.start;
    assign sum_nx = {fa_s, sum_sh[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: DONE always falls back to IDLE, start ignored elsewhere
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, serial shifting and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= bus.cin;
            cnt    <= '0;
            sum_sh <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nx;
            carry  <= fa_c;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                sum_q  <= sum_nx;
                cout_q <= fa_c;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=4.
// Per-cycle behavioural model plus directed literal expectations.
module tb_serial_adder_ctrl;
    localparam int W  = 8;
    localparam int W4 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   nfail = 0;
    bit   mon_en = 1'b0;

    serial_adder_ctrl_if #(.WIDTH(W))  i8 ();
    serial_adder_ctrl_if #(.WIDTH(W4)) i4 ();

    serial_adder_ctrl #(.WIDTH(W)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i8.slave)
    );

    serial_adder_ctrl #(.WIDTH(W4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i4.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            nfail++;
            if (nfail <= 40)
                $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: an accepted request keeps the unit busy
    // for WIDTH+1 cycles, the last of which is the done cycle.
    int           m_left = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic [W:0]   p_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if (m_left == 0) begin
            if (i8.start) begin
                m_left <= W + 1;
                p_res  <= (W+1)'(i8.a) + (W+1)'(i8.b) + (W+1)'(i8.cin);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) {m_cout, m_sum} <= p_res;
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        if (mon_en)
            chk("cycle busy/done/cout/sum",
                64'({i8.busy, i8.done, i8.cout, i8.sum}),
                64'({m_left != 0, m_left == 1, m_cout, m_sum}));
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] es,
                         input logic ec, input string nm);
        int n;
        int bc;
        bit got;
        n = 0;
        bc = 0;
        got = 1'b0;
        i8.start = 1'b1;
        i8.a = a;
        i8.b = b;
        i8.cin = cin;
        @(posedge clk);
        #1;
        i8.start = 1'b0;
        i8.a = 8'($urandom);
        i8.b = 8'($urandom);
        i8.cin = 1'($urandom);
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (i8.busy) bc++;
            if (i8.done) begin
                got = 1'b1;
                n = i;
                chk({nm, " sum"}, 64'(i8.sum), 64'(es));
                chk({nm, " cout"}, 64'(i8.cout), 64'(ec));
            end
        end
        chk({nm, " latency"}, 64'(n), 64'(W + 1));
        chk({nm, " busy cycles"}, 64'(bc), 64'(W + 1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dcnt;
        int last_t;
        bit got;
        i8.start = 1'b0;
        i8.a = '0;
        i8.b = '0;
        i8.cin = 1'b0;
        i4.start = 1'b0;
        i4.a = '0;
        i4.b = '0;
        i4.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        chk("reset busy", 64'(i8.busy), 64'(0));
        chk("reset done", 64'(i8.done), 64'(0));
        chk("reset sum", 64'(i8.sum), 64'(0));
        chk("reset cout", 64'(i8.cout), 64'(0));

        do_op(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "3C+42");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "FF+01");
        do_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "A5+5A+1");
        do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "00+00");
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "FF+FF+1");

        // Start pulse during RUN is ignored
        i8.start = 1'b1;
        i8.a = 8'h10;
        i8.b = 8'h20;
        i8.cin = 1'b0;
        @(posedge clk);
        #1;
        i8.start = 1'b0;
        dcnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (i8.done) begin
                dcnt++;
                chk("midrun sum", 64'(i8.sum), 64'(8'h30));
            end
            @(posedge clk);
            #1;
            i8.start = (n == 3);
            if (n == 3) begin
                i8.a = 8'hFF;
                i8.b = 8'hFF;
            end
        end
        chk("midrun done count", 64'(dcnt), 64'(1));

        // Reset in the middle of RUN
        i8.start = 1'b1;
        i8.a = 8'hFF;
        i8.b = 8'hFF;
        i8.cin = 1'b1;
        @(posedge clk);
        #1;
        i8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst mid busy", 64'(i8.busy), 64'(0));
        chk("rst mid done", 64'(i8.done), 64'(0));
        chk("rst mid sum", 64'(i8.sum), 64'(0));
        chk("rst mid cout", 64'(i8.cout), 64'(0));
        #2;
        rst_n = 1'b1;
        dcnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (i8.done) dcnt++;
        end
        chk("post rst done count", 64'(dcnt), 64'(0));
        chk("post rst busy", 64'(i8.busy), 64'(0));
        @(posedge clk);
        #1;

        // Start held high: one result every WIDTH+2 cycles
        i8.start = 1'b1;
        i8.a = 8'h01;
        i8.b = 8'h01;
        i8.cin = 1'b0;
        dcnt = 0;
        last_t = -1;
        for (int t = 1; t <= 50; t++) begin
            @(negedge clk);
            if (i8.done) begin
                dcnt++;
                chk("b2b sum", 64'(i8.sum), 64'(8'h02));
                if (last_t >= 0)
                    chk("b2b period", 64'(t - last_t), 64'(W + 2));
                last_t = t;
            end
        end
        chk("b2b done count", 64'(dcnt), 64'(5));
        @(posedge clk);
        #1;
        i8.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Random traffic with rare async resets
        for (int c = 0; c < 1500; c++) begin
            i8.start = ($urandom_range(3, 0) == 0);
            i8.a = 8'($urandom);
            i8.b = 8'($urandom);
            i8.cin = 1'($urandom);
            if ($urandom_range(299, 0) == 0) begin
                #1;
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i8.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Exhaustive WIDTH=4 sweep
        for (int k = 0; k < 512; k++) begin
            logic [3:0] av;
            logic [3:0] bv;
            logic       cv;
            logic [4:0] r;
            av = 4'(k);
            bv = 4'(k >> 4);
            cv = 1'(k >> 8);
            r = 5'(av) + 5'(bv) + 5'(cv);
            i4.start = 1'b1;
            i4.a = av;
            i4.b = bv;
            i4.cin = cv;
            @(posedge clk);
            #1;
            i4.start = 1'b0;
            i4.a = 4'($urandom);
            i4.b = 4'($urandom);
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (i4.done) begin
                    got = 1'b1;
                    chk("w4 sweep result", 64'({i4.cout, i4.sum}), 64'(r));
                end
            end
            if (!got) chk("w4 sweep done seen", 64'(0), 64'(1));
            @(posedge clk);
            #1;
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
